// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: picks one of three result producers (ALU, LSU, MDU)
// per cycle and registers its destination and data.
module reg_wb_arbiter #(
  parameter bit          RR_EN = 1'b1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       req_valid_i,
  input  logic [14:0]      req_rd_i,
  input  logic [95:0]      req_data_i,
  input  logic             stall_i,
  output logic [2:0]       req_ready_o,
  output logic             reg_wr_en_o,
  output logic [4:0]       reg_dr_o,
  output logic [31:0]      reg_data_o,
  output logic [1:0]       last_grant_o,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  logic [1:0]       r_ptr;
  logic             r_wr_en;
  logic [4:0]       r_dr;
  logic [31:0]      r_data;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]  w_ord0, w_ord1, w_ord2;
  logic [1:0]  w_win;
  logic [2:0]  w_ready;
  logic        w_xfer;
  logic        w_multi;
  logic [4:0]  w_rd;
  logic [31:0] w_data;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // In fixed-priority mode ptr stays 0, so the same search yields 0>1>2.
  assign w_ord0 = r_ptr;
  assign w_ord1 = inc3(r_ptr);
  assign w_ord2 = inc3(inc3(r_ptr));

  always_comb begin
    w_win   = w_ord2;
    w_ready = 3'b000;
    if (req_valid_i[w_ord0]) begin
      w_win = w_ord0;
    end else if (req_valid_i[w_ord1]) begin
      w_win = w_ord1;
    end
    if (!rst_i && !stall_i && (|req_valid_i)) begin
      w_ready = 3'b001 << w_win;
    end
  end

  assign w_xfer  = |w_ready;
  assign w_multi = (req_valid_i[0] & req_valid_i[1]) | (req_valid_i[0] & req_valid_i[2]) |
                   (req_valid_i[1] & req_valid_i[2]);

  always_comb begin
    w_rd   = req_rd_i[4:0];
    w_data = req_data_i[31:0];
    case (w_win)
      2'd1: begin
        w_rd   = req_rd_i[9:5];
        w_data = req_data_i[63:32];
      end
      2'd2: begin
        w_rd   = req_rd_i[14:10];
        w_data = req_data_i[95:64];
      end
      default: begin
        w_rd   = req_rd_i[4:0];
        w_data = req_data_i[31:0];
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr   <= 2'd0;
      r_wr_en <= 1'b0;
      r_dr    <= 5'd0;
      r_data  <= 32'd0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
    end else begin
      // x0 writes are consumed but never reach the register file
      r_wr_en <= w_xfer && (w_rd != 5'd0);
      if (w_xfer) begin
        r_dr   <= w_rd;
        r_data <= w_data;
        r_last <= w_win;
        if (RR_EN) begin
          r_ptr <= inc3(w_win);
        end
      end
      if (!stall_i && w_multi && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign req_ready_o    = w_ready;
  assign reg_wr_en_o    = r_wr_en;
  assign reg_dr_o       = r_dr;
  assign reg_data_o     = r_data;
  assign last_grant_o   = r_last;
  assign conflict_cnt_o = r_cnt;

endmodule
